// File: rtl/md_pkg.sv
// Shared op codes, FSM states and op-class helpers for the multiply/divide unit.
package md_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9,
    OP_NOP   = 4'd15
  } md_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} md_state_e;

  function automatic logic is_mul(logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div(logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed(logic [3:0] op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_acc(logic [3:0] op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_sub(logic [3:0] op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// Restoring unsigned divider core: one quotient bit per step, MSB first.
module md_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             q_bit,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh, diff;

  // quo doubles as the dividend shift register; its MSB feeds the partial remainder
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    q_bit  = ~diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= CW'(WIDTH);
    end else if (step && cnt != '0) begin
      rem <= q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], q_bit};
      cnt <= cnt - 1'b1;
    end
  end

  assign quotient  = quo;
  assign remainder = rem;
  assign last      = (cnt == '0);

endmodule

// File: rtl/mudi_unit.sv
// EX-stage multiply/divide unit owning HI/LO: fixed-latency multiply/MAC,
// iterative restoring divide, flushable in flight.
module mudi_unit
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             req_ready,
  output logic             start,
  input  logic             flush,
  input  logic             rd_hi,
  output logic [WIDTH-1:0] hl_rdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CNT_MAX = (MUL_LAT > WIDTH + 1) ? MUL_LAT : WIDTH + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  md_state_e        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, a_q, b_q;
  logic [3:0]       op_q;
  logic             a_neg, b_neg;

  logic             accept, sgn_in, div_load, div_step, div_last, div_qbit_unused;
  logic [WIDTH-1:0] mag_a, mag_b, div_quo, div_rem, q_fix, r_fix;
  logic             sx_a, sx_b;
  logic [2*WIDTH-1:0] prod, mul_res;

  assign busy      = (state != ST_IDLE);
  assign req_ready = !busy;
  assign accept    = req_valid && req_ready;
  assign start     = accept && (is_mul(req_op) || is_div(req_op));
  assign hl_rdata  = rd_hi ? hi : lo;

  assign sgn_in   = is_signed(req_op);
  assign mag_a    = (sgn_in && req_a[WIDTH-1]) ? -req_a : req_a;
  assign mag_b    = (sgn_in && req_b[WIDTH-1]) ? -req_b : req_b;
  assign div_load = start && is_div(req_op);
  assign div_step = (state == ST_DIV) && !div_last;

  md_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .q_bit    (div_qbit_unused),
    .quotient (div_quo),
    .remainder(div_rem),
    .last     (div_last)
  );

  // Sign-extend to 2*WIDTH so a single unsigned multiply yields the right low bits for both modes
  always_comb begin
    sx_a    = is_signed(op_q) && a_q[WIDTH-1];
    sx_b    = is_signed(op_q) && b_q[WIDTH-1];
    prod    = {{WIDTH{sx_a}}, a_q} * {{WIDTH{sx_b}}, b_q};
    mul_res = prod;
    if (is_acc(op_q))
      mul_res = is_sub(op_q) ? ({hi, lo} - prod) : ({hi, lo} + prod);
    q_fix = (a_neg ^ b_neg) ? -div_quo : div_quo;
    r_fix = a_neg ? -div_rem : div_rem;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_NOP;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          if (req_op == OP_MTHI) hi <= req_a;
          else if (req_op == OP_MTLO) lo <= req_a;
          else if (start) begin
            op_q        <= req_op;
            a_q         <= req_a;
            b_q         <= req_b;
            a_neg       <= sgn_in && req_a[WIDTH-1];
            b_neg       <= sgn_in && req_b[WIDTH-1];
            div_by_zero <= 1'b0;
            state       <= is_div(req_op) ? ST_DIV : ST_MUL;
            cnt         <= is_div(req_op) ? CW'(WIDTH + 1) : CW'(MUL_LAT);
          end
        end
        default: if (flush) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            if (state == ST_MUL) {hi, lo} <= mul_res;
            else if (b_q == '0) div_by_zero <= 1'b1;
            else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mudi_unit.sv
// Directed self-checking bench for mudi_unit (WIDTH=32, MUL_LAT=5).
module tb_mudi_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, req_valid, flush, rd_hi;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b, hl_rdata;
  logic        req_ready, start, busy, done, div_by_zero;

  int n_chk = 0;
  int n_bad = 0;

  mudi_unit #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .start(start),
    .flush(flush), .rd_hi(rd_hi), .hl_rdata(hl_rdata), .busy(busy),
    .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_hl(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    rd_hi = 1'b1; #1;
    chk({tag, ".hi"}, 64'(hl_rdata), 64'(ehi));
    rd_hi = 1'b0; #1;
    chk({tag, ".lo"}, 64'(hl_rdata), 64'(elo));
  endtask

  // Issue one op, wait out busy, check latency and the done pulse (exp_done<0 skips done check).
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy, input int exp_done);
    int n;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    #1;
    chk({tag, ".start"}, 64'(start), 64'(exp_busy > 0));
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = OP_NOP;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk({tag, ".busy_cyc"}, 64'(n), 64'(exp_busy));
    if (exp_done >= 0) begin
      chk({tag, ".done"}, 64'(done), 64'(exp_done));
      @(posedge clk); #1;
      chk({tag, ".done_off"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0; req_valid = 1'b0; flush = 1'b0; rd_hi = 1'b0;
    req_op = OP_NOP; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.dbz", 64'(div_by_zero), 64'd0);
    chk("rst.ready", 64'(req_ready), 64'd1);
    chk_hl("rst", 32'h0, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // multiply
    run_op("mult", OP_MULT, 32'hFFFFFFFF, 32'h2, 5, 1);
    chk_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2, 5, 1);
    chk_hl("multu", 32'h1, 32'hFFFFFFFE);

    // divide
    run_op("div", OP_DIV, 32'hFFFFFFF9, 32'h2, 33, 1);
    chk_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", OP_DIVU, 32'h7, 32'h2, 33, 1);
    chk_hl("divu", 32'h1, 32'h3);
    run_op("div_negb", OP_DIV, 32'h7, 32'hFFFFFFFE, 33, 1);
    chk_hl("div_negb", 32'h1, 32'hFFFFFFFD);
    run_op("div_min", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 1);
    chk_hl("div_min", 32'h0, 32'h80000000);
    run_op("divz", OP_DIVU, 32'h5, 32'h0, 33, -1);
    chk_hl("divz", 32'h0, 32'h80000000);
    chk("divz.flag", 64'(div_by_zero), 64'd1);
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd3; req_b = 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = OP_NOP;
    chk("divz.clr", 64'(div_by_zero), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk_hl("mult34", 32'h0, 32'd12);

    // accumulate
    run_op("mthi", OP_MTHI, 32'd5, 32'd0, 0, -1);
    run_op("mtlo", OP_MTLO, 32'd3, 32'd0, 0, -1);
    run_op("maddu", OP_MADDU, 32'd2, 32'd3, 5, 1);
    chk_hl("maddu", 32'd5, 32'd9);
    run_op("mthi0", OP_MTHI, 32'd0, 32'd0, 0, -1);
    run_op("mtlo5", OP_MTLO, 32'd5, 32'd0, 0, -1);
    run_op("msub", OP_MSUB, 32'd1, 32'd10, 5, 1);
    chk_hl("msub", 32'hFFFFFFFF, 32'hFFFFFFFB);

    // flush in busy cycle 10 of a divide
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd100; req_b = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = OP_NOP;
    repeat (9) @(posedge clk);
    #1;
    chk("flush.busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush.busy", 64'(busy), 64'd0);
    chk("flush.done", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("flush.done2", 64'(done), 64'd0);
    chk_hl("flush", 32'hFFFFFFFF, 32'hFFFFFFFB);

    // flush while idle does not block a same-cycle request
    flush = 1'b1; req_valid = 1'b1; req_op = OP_MTLO; req_a = 32'h55;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0; req_op = OP_NOP;
    chk_hl("flush_idle", 32'hFFFFFFFF, 32'h55);

    // reset in the middle of a multiply
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd3; req_b = 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = OP_NOP;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("mrst.busy", 64'(busy), 64'd0);
    chk_hl("mrst", 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("mrst.done", 64'(done), 64'd0);
    chk("mrst.busy2", 64'(busy), 64'd0);

    // MTLO held against a busy multiply
    run_op("mtlo55", OP_MTLO, 32'h55, 32'd0, 0, -1);
    rd_hi = 1'b0;
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'h10000; req_b = 32'h30000;
    @(posedge clk); #1;
    req_op = OP_MTLO; req_a = 32'd7; req_b = 32'd0;
    #1;
    n = 0;
    while (busy && n < 50) begin
      chk("hold.ready", 64'(req_ready), 64'd0);
      chk("hold.old_lo", 64'(hl_rdata), 64'h55);
      n++;
      @(posedge clk); #1;
    end
    chk("hold.busy_cyc", 64'(n), 64'd5);
    chk("hold.ready_on", 64'(req_ready), 64'd1);
    chk("hold.done", 64'(done), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = OP_NOP;
    chk("hold.busy_after", 64'(busy), 64'd0);
    chk_hl("hold", 32'd3, 32'd7);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mudi_unit.md
Name: mudi_unit

Overview:
Parametrised multiply/divide unit for the EX stage. It owns the HI/LO register pair and runs pipelined-latency multiplies, multiply-accumulate/subtract and an iterative restoring divider. Operations complete in the background while `busy` stalls later HI/LO users. A flush input aborts the operation in flight on an exception.

Parameters:
- WIDTH, 32: operand width and HI/LO width. Must be even and ≥ 8.
- MUL_LAT, 5: number of busy cycles for a multiply-class op. Must be ≥ 1.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_op  in  4  operation code (md_pkg).
- req_a  in  WIDTH  rs operand; also the data for MTHI/MTLO.
- req_b  in  WIDTH  rt operand.
- req_ready  out  1  equals !busy (combinational).
- start  out  1  req_valid & req_ready & op is arithmetic (combinational).
- flush  in  1  abort the op in flight.
- rd_hi  in  1  1 = read HI, 0 = read LO.
- hl_rdata  out  WIDTH  combinational read of HI or LO.
- busy  out  1  op in flight.
- done  out  1  one-cycle pulse after HI/LO writeback.
- div_by_zero  out  1  sticky flag for the last divide.

Behaviour:
- Reset (reset_n=0 at an edge), including mid-operation:
  - HI=LO=0, state=IDLE, busy=0, done=0, div_by_zero=0, counter=0.
  - Any op in flight is dropped.
- Accept edge: req_valid & !busy. Nothing is accepted while busy; the requester holds the request.
  - MTHI/MTLO: write HI/LO from req_a at the accept edge. No busy.
  - Arithmetic op: latch req_op, req_a, req_b, sign mode. Clear div_by_zero. Go to MUL or DIV.
- State IDLE:
  - Accepted MULT/MULTU/MADD/MADDU/MSUB/MSUBU → state MUL, counter=MUL_LAT.
  - Accepted DIV/DIVU → state DIV, counter=WIDTH+1.
- State MUL:
  - Counter decrements each edge.
  - At the edge where the counter goes 1→0, HI/LO are written and state returns to IDLE.
  - busy is high for exactly MUL_LAT cycles after the accept edge.
- State DIV:
  - Operands are first reduced to magnitudes when signed.
  - WIDTH restoring iterations, one quotient bit per cycle, MSB first.
  - The final cycle applies sign correction and writes HI/LO.
  - busy is high for WIDTH+1 cycles.
- done: high for the single cycle after the writeback edge; busy is already 0 in that cycle.
- Arithmetic:
  - MULT/MULTU: {HI,LO} = 2·WIDTH-bit product, signed or unsigned.
  - MADD(U)/MSUB(U): {HI,LO} = {HI,LO} ± product, modulo 2^(2·WIDTH). HI/LO are sampled at the writeback edge; nothing else can change them while busy.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed MIN/−1: LO = MIN (wraps), HI = 0.
  - Divide by zero: full latency still elapses. HI/LO are left unchanged. div_by_zero=1 from the writeback edge until the next accept.
- flush:
  - flush=1 while busy: state returns to IDLE on that edge; HI/LO unchanged; no done pulse.
  - flush on the writeback edge beats the writeback.
  - flush while idle has no effect; a request in the same cycle is still accepted.
- hl_rdata during busy returns the pre-operation value. Forwarding is not this block's job.
- reset_n beats flush, which beats writeback.

Decomposition:
- md_pkg holds:
  - op codes: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, NOP;
  - the state enum (IDLE, MUL, DIV);
  - helper functions is_mul, is_div, is_signed, is_acc.
- Sub-module md_div_iter: restoring divider core, parametrised by WIDTH.
  - Inputs: load, magnitude operands.
  - Outputs: one quotient bit per cycle, quotient and remainder, last.
  - Sign fixup and the HI/LO write stay in mudi_unit.

Test Plan:
1. MULT a=0xFFFFFFFF, b=0x00000002 → busy 5 cycles → HI=0xFFFFFFFF, LO=0xFFFFFFFE, done 1 cycle. Same operands with MULTU → HI=0x00000001, LO=0xFFFFFFFE.
2. DIV a=0xFFFFFFF9 (−7), b=2 → busy 33 cycles → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
3. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Then DIVU 5/0 → HI/LO unchanged, div_by_zero=1; it clears on the next accepted MULT.
4. MTHI 5, MTLO 3, then MADDU 2×3 → HI=5, LO=9. Then MTHI 0, MTLO 5, MSUB 1×10 → HI=0xFFFFFFFF, LO=0xFFFFFFFB.
5. flush in busy cycle 10 of a DIV → busy=0 next cycle, HI/LO unchanged, no done. reset_n=0 during a MULT → HI=LO=0, busy=0.
6. req_valid MTLO 7 held while a MULT is busy → req_ready=0 and hl_rdata shows old LO. MTLO is accepted on the first cycle busy=0; LO=7 after that edge. MULT result in HI is preserved.
